// File: rtl/uart_tx_cfg_if.sv
// Word/config handshake bundle for uart_tx_cfg.
// master drives word+config+valid, slave returns READY.
interface uart_tx_cfg_if #(
  parameter int DATA_WIDTH = 8,
  parameter int DIV_W      = 8
);
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  DATA_VALID;
  logic                  READY;
  logic                  PAR_EN;
  logic                  PAR_TYP;
  logic                  STOP2;
  logic [DIV_W-1:0]      DIV;

  modport master (
    output P_DATA, DATA_VALID,
    output PAR_EN, PAR_TYP, STOP2, DIV,
    input  READY
  );

  modport slave (
    input  P_DATA, DATA_VALID,
    input  PAR_EN, PAR_TYP, STOP2, DIV,
    output READY
  );
endinterface

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: start/data/parity/stop framing.
// Ports: CLK, RST (async low), bus (slave), TX_OUT, BUSY, TX_DONE.
module uart_tx_cfg #(
  parameter int DATA_WIDTH = 8,
  parameter int DIV_W      = 8
) (
  input  logic         CLK,
  input  logic         RST,
  uart_tx_cfg_if.slave bus,
  output logic         TX_OUT,
  output logic         BUSY,
  output logic         TX_DONE
);
  localparam int IW = $clog2(DATA_WIDTH + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA,
    S_PARITY, S_STOP1, S_STOP2
  } state_e;

  state_e state_q, state_d;
  logic [DIV_W-1:0]      cnt_q, cnt_d;
  logic [DIV_W-1:0]      div_q, div_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic par_q, par_d;
  logic pe_q, pe_d;
  logic s2_q, s2_d;
  logic tx_q, tx_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic bit_end, ready, accept;

  assign bit_end   = (cnt_q == div_q);
  // done_q is high exactly in the last stop-bit cycle
  assign ready     = (state_q == S_IDLE) || done_q;
  assign accept    = bus.DATA_VALID && ready;
  assign bus.READY = ready;
  assign TX_OUT    = tx_q;
  assign BUSY      = busy_q;
  assign TX_DONE   = done_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    idx_d   = idx_q;
    data_d  = data_q;
    par_d   = par_q;
    pe_d    = pe_q;
    s2_d    = s2_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    if (state_q != S_IDLE) begin
      cnt_d = bit_end ? DIV_W'(1)
                      : cnt_q + 1'b1;
    end
    unique case (state_q)
      S_START: if (bit_end) begin
        state_d = S_DATA;
        idx_d   = '0;
        tx_d    = data_q[0];
        data_d  = data_q >> 1;
      end
      S_DATA: if (bit_end) begin
        if (idx_q == IW'(DATA_WIDTH - 1)) begin
          state_d = pe_q ? S_PARITY : S_STOP1;
          tx_d    = pe_q ? par_q : 1'b1;
        end else begin
          idx_d  = idx_q + 1'b1;
          tx_d   = data_q[0];
          data_d = data_q >> 1;
        end
      end
      S_PARITY: if (bit_end) begin
        state_d = S_STOP1;
        tx_d    = 1'b1;
      end
      S_STOP1: if (bit_end) begin
        if (s2_q) begin
          state_d = S_STOP2;
        end else begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end
      end
      S_STOP2: if (bit_end) begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: ;
    endcase
    // accept overrides end-of-frame for back-to-back
    if (accept) begin
      state_d = S_START;
      cnt_d   = DIV_W'(1);
      idx_d   = '0;
      tx_d    = 1'b0;
      busy_d  = 1'b1;
      data_d  = bus.P_DATA;
      pe_d    = bus.PAR_EN;
      s2_d    = bus.STOP2;
      par_d   = bus.PAR_TYP ? ~^bus.P_DATA
                            : ^bus.P_DATA;
      div_d   = (bus.DIV == '0) ? DIV_W'(1)
                                : bus.DIV;
    end
    // look ahead: is next cycle the last stop cycle
    done_d = (cnt_d == div_d) &&
             ((state_d == S_STOP1 && !s2_d) ||
              state_d == S_STOP2);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      div_q   <= DIV_W'(1);
      idx_q   <= '0;
      data_q  <= '0;
      par_q   <= 1'b0;
      pe_q    <= 1'b0;
      s2_q    <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      par_q   <= par_d;
      pe_q    <= pe_d;
      s2_q    <= s2_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end
endmodule
